if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage. Holds the PC, issues read requests to the
//   instruction memory and presents each returned word to the IF/ID register
//   together with its PC + PC_STEP. Handles decode stalls, branch/jump
//   redirects and discarding of stale memory responses.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   stall            decode hazard hold
//   branch_taken     redirect to branch_target (wins over jump)
//   jump             redirect to jump_target
//   imem_req/addr    read request and address (current PC)
//   imem_valid/rdata read response
//   inst, adder1     delivered instruction and its PC + PC_STEP
//   flush            one-cycle IF/ID clear on redirect
//   fetch_valid      inst/adder1 are fresh this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] adder1,
    output logic        flush,
    output logic        fetch_valid
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] adder1_q, adder1_d;
    logic [31:0] cap_q, cap_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        flush_q, flush_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_next;

    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_next  = pc_q + STEP;  // wraps modulo 2^32

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        adder1_d      = adder1_q;
        cap_d         = cap_q;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;

        if (redirect) begin
            pc_d    = target;
            flush_d = 1'b1;
            // A request still in flight (or a DRAIN not yet satisfied) must
            // have its one response swallowed before fetching the target.
            // A response arriving this very cycle is that response.
            if (state_q != HOLD && !imem_valid) state_d = DRAIN;
            else                                state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH, WAIT: begin
                    if (imem_valid) begin
                        if (stall) begin
                            cap_d   = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            inst_d        = imem_rdata;
                            adder1_d      = pc_next;
                            fetch_valid_d = 1'b1;
                            pc_d          = pc_next;
                            state_d       = FETCH;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_d        = cap_q;
                        adder1_d      = pc_next;
                        fetch_valid_d = 1'b1;
                        pc_d          = pc_next;
                        state_d       = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            adder1_q      <= '0;
            cap_q         <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            adder1_q      <= adder1_d;
            cap_q         <= cap_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
        end
    end

    // Request is suppressed while reset is held so the first request is seen
    // in the first cycle after reset deasserts.
    assign imem_req    = !rst && (state_q == FETCH || state_q == WAIT);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign adder1      = adder1_q;
    assign flush       = flush_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT, RESET_PC = 0
    logic        rst, stall, branch_taken, jump, imem_valid;
    logic [31:0] branch_target, jump_target, imem_rdata;
    logic        imem_req, flush, fetch_valid;
    logic [31:0] imem_addr, inst, adder1;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst(inst), .adder1(adder1), .flush(flush), .fetch_valid(fetch_valid)
    );

    // wrap DUT, RESET_PC = FFFF_FFFC
    logic        rst2, valid2;
    logic [31:0] rdata2;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;
    logic        req2, flush2, fv2;
    logic [31:0] addr2, inst2, adder2;

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(zero1),
        .branch_taken(zero1), .branch_target(zero32),
        .jump(zero1), .jump_target(zero32),
        .imem_req(req2), .imem_addr(addr2),
        .imem_valid(valid2), .imem_rdata(rdata2),
        .inst(inst2), .adder1(adder2), .flush(flush2), .fetch_valid(fv2)
    );

    typedef struct {
        logic        rst, stall, br, jmp, valid;
        logic [31:0] bt, jt, rdata;
        logic        e_req;
        logic [31:0] e_addr, e_inst, e_adder1;
        logic        e_flush, e_fv;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic v(input logic r, input logic s, input logic br, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic vl, input logic [31:0] rd,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_inst,
                     input logic [31:0] e_a1, input logic e_fl, input logic e_fv);
        vec_t t;
        t.rst = r; t.stall = s; t.br = br; t.bt = bt; t.jmp = j; t.jt = jt;
        t.valid = vl; t.rdata = rd;
        t.e_req = e_req; t.e_addr = e_addr; t.e_inst = e_inst; t.e_adder1 = e_a1;
        t.e_flush = e_fl; t.e_fv = e_fv;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    initial begin
        rst = 1; stall = 0; branch_taken = 0; jump = 0; imem_valid = 0;
        branch_target = 0; jump_target = 0; imem_rdata = 0;
        rst2 = 1; valid2 = 0; rdata2 = 0;

        //  rst st br bt        jmp jt        vld rdata          req addr      inst          adder1    fl fv
        v(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h0,   32'h0,        32'h0,   0, 0); // 0 reset
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0000,  1, 32'h0,   32'h0,        32'h0,   0, 0); // 1
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0004,  1, 32'h4,   32'hD000_0000, 32'h4,  0, 1); // 2
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0008,  1, 32'h8,   32'hD000_0004, 32'h8,  0, 1); // 3
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_000C,  1, 32'hC,   32'hD000_0008, 32'hC,  0, 1); // 4
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h10,  32'hD000_000C, 32'h10, 0, 1); // 5 -> WAIT
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h10,  32'hD000_000C, 32'h10, 0, 0); // 6 WAIT
        v(0, 0, 1, 32'h40,  0, 32'h0,   0, 32'h0,          1, 32'h10,  32'hD000_000C, 32'h10, 0, 0); // 7 branch -> DRAIN
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h40,  32'hD000_000C, 32'h10, 1, 0); // 8 DRAIN
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hBAD0_0010,  0, 32'h40,  32'hD000_000C, 32'h10, 0, 0); // 9 stale word dropped
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0040,  1, 32'h40,  32'hD000_000C, 32'h10, 0, 0); // 10
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h44,  32'hD000_0040, 32'h44, 0, 1); // 11 delay 1
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h44,  32'hD000_0040, 32'h44, 0, 0); // 12 delay 2
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h44,  32'hD000_0040, 32'h44, 0, 0); // 13 delay 3
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0044,  1, 32'h44,  32'hD000_0040, 32'h44, 0, 0); // 14 valid
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0048,  1, 32'h48,  32'hD000_0044, 32'h48, 0, 1); // 15
        v(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'hD000_004C,  1, 32'h4C,  32'hD000_0048, 32'h4C, 0, 1); // 16 stall -> HOLD
        v(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h4C,  32'hD000_0048, 32'h4C, 0, 0); // 17 HOLD
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          0, 32'h4C,  32'hD000_0048, 32'h4C, 0, 0); // 18 release
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0050,  1, 32'h50,  32'hD000_004C, 32'h50, 0, 1); // 19
        v(0, 0, 1, 32'h80,  1, 32'h100, 1, 32'hBAD0_0054,  1, 32'h54,  32'hD000_0050, 32'h54, 0, 1); // 20 br+jmp with valid
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0080,  1, 32'h80,  32'hD000_0050, 32'h54, 1, 0); // 21 branch wins
        v(0, 1, 0, 32'h0,   1, 32'h200, 1, 32'hBAD0_0084,  1, 32'h84,  32'hD000_0080, 32'h84, 0, 1); // 22 jump over stall
        v(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0200,  1, 32'h200, 32'hD000_0080, 32'h84, 1, 0); // 23 capture -> HOLD
        v(0, 1, 1, 32'h300, 0, 32'h0,   0, 32'h0,          0, 32'h200, 32'hD000_0080, 32'h84, 0, 0); // 24 branch in HOLD
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0300,  1, 32'h300, 32'hD000_0080, 32'h84, 1, 0); // 25
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h304, 32'hD000_0300, 32'h304,0, 1); // 26 -> WAIT
        v(0, 0, 0, 32'h0,   1, 32'h400, 0, 32'h0,          1, 32'h304, 32'hD000_0300, 32'h304,0, 0); // 27 jump -> DRAIN
        v(0, 0, 1, 32'h500, 0, 32'h0,   0, 32'h0,          0, 32'h400, 32'hD000_0300, 32'h304,1, 0); // 28 second redirect
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hBAD0_0304,  0, 32'h500, 32'hD000_0300, 32'h304,1, 0); // 29 one drop
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0500,  1, 32'h500, 32'hD000_0300, 32'h304,0, 0); // 30
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h504, 32'hD000_0500, 32'h504,0, 1); // 31 -> WAIT
        v(1, 1, 1, 32'h700, 1, 32'h800, 1, 32'hBAD0_0504,  0, 32'h504, 32'hD000_0500, 32'h504,0, 0); // 32 reset wins
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h0,   32'h0,        32'h0,   0, 0); // 33
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hD000_0000,  1, 32'h0,   32'h0,        32'h0,   0, 0); // 34
        v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,          1, 32'h4,   32'hD000_0000, 32'h4,  0, 1); // 35

        // initial reset edge for both DUTs
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].bt;
            jump          = vecs[i].jmp;
            jump_target   = vecs[i].jt;
            imem_valid    = vecs[i].valid;
            imem_rdata    = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d req", i),    32'(imem_req),    32'(vecs[i].e_req));
            chk($sformatf("v%0d addr", i),   imem_addr,        vecs[i].e_addr);
            chk($sformatf("v%0d inst", i),   inst,             vecs[i].e_inst);
            chk($sformatf("v%0d adder1", i), adder1,           vecs[i].e_adder1);
            chk($sformatf("v%0d flush", i),  32'(flush),       32'(vecs[i].e_flush));
            chk($sformatf("v%0d fv", i),     32'(fetch_valid), 32'(vecs[i].e_fv));
            @(negedge clk);
        end

        // PC wrap with zero-wait memory
        rst2 = 0; valid2 = 1; rdata2 = 32'hE000_0001;
        #1;
        chk("wrap req0",  32'(req2), 32'h1);
        chk("wrap addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        rdata2 = 32'hE000_0002;
        #1;
        chk("wrap addr1",   addr2,  32'h0000_0000);
        chk("wrap inst1",   inst2,  32'hE000_0001);
        chk("wrap adder1a", adder2, 32'h0000_0000);
        chk("wrap fv1",     32'(fv2), 32'h1);
        @(negedge clk);
        valid2 = 0;
        #1;
        chk("wrap addr2",   addr2,  32'h0000_0004);
        chk("wrap inst2",   inst2,  32'hE000_0002);
        chk("wrap adder1b", adder2, 32'h0000_0004);
        chk("wrap flush",   32'(flush2), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
